// File: rtl/blockram_pkg.sv
// Shared definitions for the dual-port block RAM: default geometry and the
// clear-sequencer state encoding.
package blockram_pkg;

   // Default geometry: 64 entries of 64 bits (8 byte lanes).
   localparam int DEFAULT_ELEMENT_BITS = 64;
   localparam int DEFAULT_NUMBER_SETS  = 64;

   // Clear-sequencer state encoding, kept as plain constants so that older
   // tooling in the flow sees simple vectors.
   typedef logic [0:0] state_t;
   localparam state_t CLEAR = 1'b0;
   localparam state_t READY = 1'b1;

endpackage : blockram_pkg

// File: rtl/blockram_clear_fsm.sv
// Clear sequencer for the dual-port block RAM. After reset, or on a clear
// request while READY, it sweeps every entry once (one entry per cycle) and
// then returns to READY. Clear requests during a sweep are ignored.
module blockram_clear_fsm
   import blockram_pkg::*;
#(
   parameter  int NUMBER_SETS = DEFAULT_NUMBER_SETS,
   localparam int PTR_W       = $clog2(NUMBER_SETS)
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             clear_in,
   output state_t           state_o,
   output logic [PTR_W-1:0] clear_ptr_o,
   output logic             init_busy_out
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUMBER_SETS - 1);

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Next-state logic: advance the sweep, or start one on a clear request.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            // The pointer wraps to 0 naturally after the last entry.
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == LAST_PTR) begin
               state_d = READY;
            end
         end
         default: begin
            if (clear_in) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
      endcase
   end

   // State register; reset always restarts the sweep from entry 0.
   always_ff @(posedge clk_in or negedge reset_in) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      if (!reset_in) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign state_o       = state_q;
   assign clear_ptr_o   = ptr_q;
   assign init_busy_out = (state_q == CLEAR);

endmodule : blockram_clear_fsm

// File: rtl/dual_port_blockram.sv
// Dual-port (one write, one read) block RAM with per-byte write mask,
// write-first forwarding on same-address collisions and a hardware clear
// sweep driven by blockram_clear_fsm.
// Optional feature: define BLOCKRAM_OUTPUT_REG_EN to add a registered output
// stage (read latency 2 instead of 1).
module dual_port_blockram
   import blockram_pkg::*;
#(
   parameter  int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_BITS,
   parameter  int NUMBER_SETS                 = DEFAULT_NUMBER_SETS,
   localparam int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
   localparam int NUMBER_BYTES                = SINGLE_ELEMENT_SIZE_IN_BITS / 8
) (
   input  logic                                   clk_in,
   input  logic                                   reset_in,
   input  logic                                   clear_in,
   output logic                                   init_busy_out,
   input  logic                                   write_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
   input  logic [NUMBER_BYTES-1:0]                write_byte_mask_in,
   input  logic                                   read_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out,
   output logic                                   read_valid_out
);

   state_t                                 state;
   logic [SET_PTR_WIDTH_IN_BITS-1:0]       clear_ptr;
   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem_q [NUMBER_SETS];
   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd_data_d, rd_data_q;
   logic                                   rd_valid_q;
   logic                                   rd_accept;

   blockram_clear_fsm #(
      .NUMBER_SETS (NUMBER_SETS)
   ) u_clear_fsm (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .clear_in      (clear_in),
      .state_o       (state),
      .clear_ptr_o   (clear_ptr),
      .init_busy_out (init_busy_out)
   );

   // Array update: the clear sweep owns the write port while CLEAR,
   // otherwise masked byte lanes are written.
   always_ff @(posedge clk_in) begin
      // NOTE: the array has no reset; the clear sweep zeroes it, which keeps
      // it mappable onto block RAM.
      if (state == CLEAR) begin
         mem_q[clear_ptr] <= '0;
      end else if (write_en_in) begin
         for (int k = 0; k < NUMBER_BYTES; k++) begin
            if (write_byte_mask_in[k]) begin
               mem_q[write_set_addr_in][8*k +: 8] <= write_element_in[8*k +: 8];
            end
         end
      end
   end

   assign rd_accept = (state == READY) && read_en_in;

   // Write-first forwarding: on a same-address collision the masked lanes
   // take the incoming write data, unmasked lanes the stored data.
   always_comb begin
      rd_data_d = mem_q[read_set_addr_in];
      for (int k = 0; k < NUMBER_BYTES; k++) begin
         if (write_en_in && (write_set_addr_in == read_set_addr_in) &&
             write_byte_mask_in[k]) begin
            rd_data_d[8*k +: 8] = write_element_in[8*k +: 8];
         end
      end
   end

   // First read stage: capture data on accepted reads, hold otherwise.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) begin
            rd_data_q <= rd_data_d;
         end
      end
   end

`ifdef BLOCKRAM_OUTPUT_REG_EN
   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] out_data_q;
   logic                                   out_valid_q;

   // Output register stage: forwards stage-1 results one cycle later.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= rd_valid_q;
         if (rd_valid_q) begin
            out_data_q <= rd_data_q;
         end
      end
   end

   assign read_element_out = out_data_q;
   assign read_valid_out   = out_valid_q;
`else
   assign read_element_out = rd_data_q;
   assign read_valid_out   = rd_valid_q;
`endif

endmodule : dual_port_blockram

// File: doc/dual_port_blockram.md
DUAL_PORT_BLOCKRAM -- requirements
Module: dual_port_blockram

Interface
REQ-001 SHALL have parameter SINGLE_ELEMENT_SIZE_IN_BITS, default 64, the element width; a multiple of 8.
REQ-002 SHALL have parameter NUMBER_SETS, default 64, the number of entries; a power of two, at least 2.
REQ-003 SHALL have derived parameter SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS), which is not overridable.
REQ-004 SHALL have derived parameter NUMBER_BYTES = SINGLE_ELEMENT_SIZE_IN_BITS/8.
REQ-005 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_in  input  1  asynchronous, active-low reset.
REQ-007 clear_in  input  1  request to zero the whole array.
REQ-008 init_busy_out  output  1  high while the clear sweep runs.
REQ-009 write_en_in  input  1  write request.
REQ-010 write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write index.
REQ-011 write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
REQ-012 write_byte_mask_in  input  NUMBER_BYTES  per-byte write enable; bit k covers bits [8k+7:8k].
REQ-013 read_en_in  input  1  read request.
REQ-014 read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read index.
REQ-015 read_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read data.
REQ-016 read_valid_out  output  1  one-cycle qualifier for read_element_out.

Function
REQ-017 SHALL implement FSM states CLEAR and READY.
REQ-018 CLEAR SHALL write zero to entry clear_ptr each cycle and increment clear_ptr.
REQ-019 CLEAR SHALL go to READY on the cycle that clears entry NUMBER_SETS-1, so the sweep takes exactly NUMBER_SETS cycles.
REQ-020 In READY, clear_in=1 SHALL set clear_ptr=0 and enter CLEAR on the next edge.
REQ-021 clear_in SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-022 init_busy_out SHALL be 1 exactly while the state is CLEAR.
REQ-023 In CLEAR, write_en_in and read_en_in SHALL be ignored, and read_valid_out SHALL be 0.
REQ-024 In READY, with write_en_in=1, the masked bytes of write_element_in SHALL be stored at write_set_addr_in; unmasked bytes SHALL be unchanged.
REQ-025 With write_en_in=1 and an all-zero mask, the array SHALL NOT change.
REQ-026 In READY, with read_en_in=1, the entry SHALL appear on read_element_out with read_valid_out=1 one cycle later.
REQ-027 When there is no accepted read, read_element_out SHALL hold its last value and read_valid_out SHALL be 0.
REQ-028 A read and write to the same address in the same cycle SHALL be write-first: masked bytes return new data, unmasked bytes return stored data.
REQ-029 A read and write to different addresses in the same cycle SHALL both complete independently.
REQ-030 Back-to-back reads SHALL be accepted every cycle with no bubbles.

Reset
REQ-031 Asserting reset_in=0 SHALL immediately set state=CLEAR, clear_ptr=0, init_busy_out=1, read_valid_out=0 and read_element_out=0.
REQ-032 After release, the sweep SHALL start on the first rising edge.
REQ-033 Reset asserted mid-sweep or mid-read SHALL abort the operation and restart the sweep from entry 0; the array contents need not be reset directly.

Configuration
REQ-034 Macro BLOCKRAM_OUTPUT_REG_EN defined: SHALL add a registered output stage to read_element_out and read_valid_out, giving read latency 2.
REQ-035 With BLOCKRAM_OUTPUT_REG_EN, the extra stage SHALL reset to 0.
REQ-036 With BLOCKRAM_OUTPUT_REG_EN, write-first forwarding SHALL still apply; forwarding is evaluated in the request cycle.
REQ-037 Macro BLOCKRAM_OUTPUT_REG_EN undefined: read latency SHALL be 1, as specified in Function.

Structure
REQ-038 Package blockram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the default constants for element width and set count.
REQ-039 The clear sequencer SHALL be sub-module blockram_clear_fsm.
- Outputs: state, clear_ptr, init_busy_out.
- The array, masking and forwarding SHALL stay in the top module.

Verification
REQ-040 Reset release, no activity -> init_busy_out=1 for exactly 64 cycles; reads of addresses 0..63 then return 0.
REQ-041 Write 0x1122334455667788 at addr 5 with mask 0xFF, then write 0xAAAAAAAAAAAAAAAA at addr 5 with mask 0x0F -> a read of addr 5 returns 0x11223344AAAAAAAA one cycle later (two without the macro undefined; i.e. two cycles with BLOCKRAM_OUTPUT_REG_EN).
REQ-042 Addr 9 holds 0; in the same cycle write 0xDEADBEEF00000000 with mask 0xF0 and read addr 9 -> returns 0xDEADBEEF00000000.
REQ-043 Write all 64 entries with random data, then perform 64 back-to-back reads -> read_valid_out is high for 64 consecutive cycles and every value matches.
REQ-044 Assert clear_in after writes -> 64 busy cycles with reads ignored; afterwards every entry reads 0.
REQ-045 Assert reset_in=0 at cycle 30 of a sweep -> outputs are 0 immediately; after release, a full 64-cycle sweep runs again.
